// File: rtl/fns_pkg.sv
// Shared constants for the 24-wire FNS crosstalk-avoidance link.
// Holds the Fibonacci weights FNS01..FNS26, the decoded word width, the
// per-digit weight helper, and the 10-entry MSB group-code table. The
// transmit encoder uses the same table.
package fns_pkg;

  localparam int IBLEN24 = 18;  // decoded data word width
  localparam int CODEW   = 24;  // codeword width
  localparam int NDIG    = 20;  // Fibonacci-weighted digits below the group code
  localparam int NGRP    = 10;  // number of legal group codes

  typedef logic [IBLEN24-1:0] word_t;

  // Offset and legality for one group code
  typedef struct packed {
    word_t offset;
    logic  illegal;
  } grp_lut_t;

  // n-th FNS number with FNS(1) = FNS(2) = 1
  function automatic int fns(input int n);
    int a;
    int b;
    int t;
    a = 32'sd1;
    b = 32'sd1;
    for (int i = 3; i <= n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  localparam int FNS01 = fns(1);
  localparam int FNS02 = fns(2);
  localparam int FNS03 = fns(3);
  localparam int FNS04 = fns(4);
  localparam int FNS05 = fns(5);
  localparam int FNS06 = fns(6);
  localparam int FNS07 = fns(7);
  localparam int FNS08 = fns(8);
  localparam int FNS09 = fns(9);
  localparam int FNS10 = fns(10);
  localparam int FNS11 = fns(11);
  localparam int FNS12 = fns(12);
  localparam int FNS13 = fns(13);
  localparam int FNS14 = fns(14);
  localparam int FNS15 = fns(15);
  localparam int FNS16 = fns(16);
  localparam int FNS17 = fns(17);
  localparam int FNS18 = fns(18);
  localparam int FNS19 = fns(19);
  localparam int FNS20 = fns(20);
  localparam int FNS21 = fns(21);
  localparam int FNS22 = fns(22);
  localparam int FNS23 = fns(23);
  localparam int FNS24 = fns(24);
  localparam int FNS25 = fns(25);
  localparam int FNS26 = fns(26);

  // Legal group codes and their offsets, index-aligned
  localparam logic [3:0] GRP_CODE [NGRP] = '{
    4'b0000, 4'b0001, 4'b1000, 4'b1001, 4'b0011,
    4'b1100, 4'b0110, 4'b0111, 4'b1110, 4'b1111
  };

  localparam word_t GRP_OFS [NGRP] = '{
    word_t'(32'sd0),
    word_t'(FNS21),
    word_t'(FNS23),
    word_t'(FNS21 + FNS23),
    word_t'(FNS21 + FNS24),
    word_t'(FNS23 + FNS24),
    word_t'(FNS24 + FNS24),
    word_t'(FNS24 + FNS24 + FNS21),
    word_t'(FNS24 + FNS24 + FNS23),
    word_t'(FNS24 + FNS24 + FNS23 + FNS21)
  };

  // Weight of digit k: bit 0 weighs FNS01, bit k (k >= 1) weighs FNS(k+1)
  function automatic word_t digit_weight(input int k);
    if (k == 32'sd0) begin
      return word_t'(FNS01);
    end else begin
      return word_t'(fns(k + 32'sd1));
    end
  endfunction

endpackage

// File: rtl/idp_decoder_24_if.sv
// Stream interface of the FNS receive decoder.
// Input side : in_valid / in_ready / codein (24-bit codeword)
// Output side: out_valid / out_ready / dataout (IBLEN24) / out_err
// slave  = decoder view, master = upstream/downstream environment view.
interface idp_decoder_24_if;

  logic                     in_valid;
  logic                     in_ready;
  logic [fns_pkg::CODEW-1:0] codein;
  logic                     out_valid;
  logic                     out_ready;
  fns_pkg::word_t           dataout;
  logic                     out_err;

  modport slave (
    input  in_valid, codein, out_ready,
    output in_ready, out_valid, dataout, out_err
  );

  modport master (
    output in_valid, codein, out_ready,
    input  in_ready, out_valid, dataout, out_err
  );

endinterface

// File: rtl/idp_group_lut.sv
// Combinational group-code lookup: 4-bit MSB group code -> {offset, illegal}.
// Ports:
//   code : 4-bit group code (codeword bits [23:20])
//   lut  : offset (IBLEN24 bits, 0 when illegal) and illegal flag
module idp_group_lut
  import fns_pkg::*;
(
  input  logic [3:0] code,
  output grp_lut_t   lut
);

  word_t offset_s;
  logic  hit_s;

  // Table codes are distinct, so OR-ing the masked offsets selects the single match
  always_comb begin
    offset_s = '0;
    hit_s    = 1'b0;
    for (int i = 0; i < NGRP; i++) begin
      offset_s = offset_s | ((code == GRP_CODE[i]) ? GRP_OFS[i] : '0);
      hit_s    = hit_s | (code == GRP_CODE[i]);
    end
  end

  assign lut.offset  = offset_s;
  assign lut.illegal = ~hit_s;

endmodule

// File: rtl/idp_decoder_24.sv
// FNS 24-wire receive decoder: 3-stage valid/ready pipeline turning a
// 24-bit codeword (group code + 20 Fibonacci-weighted digits) into an
// IBLEN24-bit data word, flagging illegal group codes.
// Ports:
//   clock     : rising-edge clock
//   reset_n   : synchronous active-low reset
//   bus       : stream interface (slave modport)
//   err_count : saturating count of illegal words delivered downstream
module idp_decoder_24
  import fns_pkg::*;
#(
  parameter int ERRW = 16
)
(
  input  logic            clock,
  input  logic            reset_n,
  idp_decoder_24_if.slave bus,
  output logic [ERRW-1:0] err_count
);

  // Stage valids
  logic s1_v_r;
  logic s2_v_r;
  logic s3_v_r;

  // Stage 1: digits, offset, error
  logic [NDIG-1:0] s1_dig_r;
  word_t           s1_off_r;
  logic            s1_err_r;

  // Stage 2: partial sums, offset, error
  word_t s2_hi_r;
  word_t s2_lo_r;
  word_t s2_off_r;
  logic  s2_err_r;

  // Stage 3: output registers
  word_t s3_data_r;
  logic  s3_err_r;

  logic [ERRW-1:0] err_cnt_r;

  grp_lut_t lut_s;
  word_t    hi_sum_s;
  word_t    lo_sum_s;
  logic     s1_load_s;
  logic     s2_load_s;
  logic     s3_load_s;

  // A stage loads when empty or when its successor advances; empty stages
  // load even under a downstream stall, which compresses bubbles.
  assign s3_load_s = ~s3_v_r | bus.out_ready;
  assign s2_load_s = ~s2_v_r | s3_load_s;
  assign s1_load_s = ~s1_v_r | s2_load_s;

  assign bus.in_ready = s1_load_s;

  idp_group_lut u_group_lut (
    .code (bus.codein[CODEW-1:CODEW-4]),
    .lut  (lut_s)
  );

  // Two 10-digit partial sums from the stage-1 digits
  always_comb begin
    lo_sum_s = '0;
    hi_sum_s = '0;
    for (int k = 0; k < 10; k++) begin
      lo_sum_s = lo_sum_s + (s1_dig_r[k]      ? digit_weight(k)      : '0);
      hi_sum_s = hi_sum_s + (s1_dig_r[k + 10] ? digit_weight(k + 10) : '0);
    end
  end

  // Stage valids, output registers and error counter (reset)
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_v_r    <= 1'b0;
      s2_v_r    <= 1'b0;
      s3_v_r    <= 1'b0;
      s3_data_r <= '0;
      s3_err_r  <= 1'b0;
      err_cnt_r <= '0;
    end else begin
      if (s1_load_s) begin
        s1_v_r <= bus.in_valid;
      end
      if (s2_load_s) begin
        s2_v_r <= s1_v_r;
      end
      if (s3_load_s) begin
        s3_v_r <= s2_v_r;
      end
      if (s3_load_s && s2_v_r) begin
        // Final add; wraps mod 2^IBLEN24, unreachable for legal codewords
        s3_data_r <= s2_hi_r + s2_lo_r + s2_off_r;
        s3_err_r  <= s2_err_r;
      end
      if (s3_v_r && bus.out_ready && s3_err_r && !(&err_cnt_r)) begin
        err_cnt_r <= err_cnt_r + ERRW'(1'b1);
      end
    end
  end

  // Stage 1 and 2 data registers (no reset; qualified by the valids)
  always_ff @(posedge clock) begin
    if (s1_load_s && bus.in_valid) begin
      s1_dig_r <= bus.codein[NDIG-1:0];
      s1_off_r <= lut_s.offset;
      s1_err_r <= lut_s.illegal;
    end
    if (s2_load_s && s1_v_r) begin
      s2_hi_r  <= hi_sum_s;
      s2_lo_r  <= lo_sum_s;
      s2_off_r <= s1_off_r;
      s2_err_r <= s1_err_r;
    end
  end

  assign bus.out_valid = s3_v_r;
  assign bus.dataout   = s3_data_r;
  assign bus.out_err   = s3_err_r;
  assign err_count     = err_cnt_r;

endmodule

// File: tb/tb_idp_decoder_24.sv
// Self-checking bench for idp_decoder_24: directed vector table, latency,
// back-to-back stream, stall, mid-stream reset, and a random phase scored
// against an arithmetic reference model. A second instance with a 2-bit
// error counter exposes counter saturation on the same stream.
module tb_idp_decoder_24;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] err_count_a;
  logic [1:0]  err_count_b;

  int checks = 0;
  int errors = 0;

  idp_decoder_24_if bus_a();
  idp_decoder_24_if bus_b();

  idp_decoder_24 #(.ERRW(16)) dut_a (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus_a),
    .err_count (err_count_a)
  );

  idp_decoder_24 #(.ERRW(2)) dut_b (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus_b),
    .err_count (err_count_b)
  );

  assign bus_b.in_valid  = bus_a.in_valid;
  assign bus_b.codein    = bus_a.codein;
  assign bus_b.out_ready = bus_a.out_ready;

  always #5 clock = ~clock;

  typedef struct packed {
    logic [17:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    logic [23:0] code;
    logic [17:0] data;
    logic        err;
  } vec_t;

  // Reference: offset from the group rule plus Fibonacci-weighted digits
  function automatic exp_t ref_decode(input logic [23:0] cw);
    int   f [0:26];
    int   sum;
    exp_t r;
    f[0] = 0;
    f[1] = 1;
    f[2] = 1;
    for (int n = 3; n <= 26; n++) f[n] = f[n-1] + f[n-2];
    r.err = 1'b0;
    case (cw[23:20])
      4'b0000: sum = 0;
      4'b0001: sum = f[21];
      4'b1000: sum = f[23];
      4'b1001: sum = f[21] + f[23];
      4'b0011: sum = f[21] + f[24];
      4'b1100: sum = f[23] + f[24];
      4'b0110: sum = 2 * f[24];
      4'b0111: sum = 2 * f[24] + f[21];
      4'b1110: sum = 2 * f[24] + f[23];
      4'b1111: sum = 2 * f[24] + f[23] + f[21];
      default: begin sum = 0; r.err = 1'b1; end
    endcase
    if (cw[0]) sum += 1;
    for (int k = 1; k < 20; k++) if (cw[k]) sum += f[k+1];
    r.data = 18'(sum);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Scoreboard and error-count model, sampled on the falling edge
  exp_t sb_q[$];
  exp_t mon_e;
  int   model_a = 0;
  int   model_b = 0;
  bit   armed   = 1'b0;

  always @(negedge clock) begin
    if (!reset_n) begin
      sb_q.delete();
      model_a = 0;
      model_b = 0;
      armed   = 1'b1;
    end else if (armed) begin
      chk("err_count_a", 32'(err_count_a), 32'(model_a));
      chk("err_count_b", 32'(err_count_b), 32'(model_b));
      if (bus_a.out_valid && bus_a.out_ready) begin
        chk("sb_pending", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          chk("sb_data", 32'(bus_a.dataout), 32'(mon_e.data));
          chk("sb_err", 32'(bus_a.out_err), 32'(mon_e.err));
          if (mon_e.err) begin
            if (model_a < 65535) model_a++;
            if (model_b < 3) model_b++;
          end
        end
      end
      if (bus_a.in_valid && bus_a.in_ready) sb_q.push_back(ref_decode(bus_a.codein));
    end
  end

  // One isolated word: accepted at the next edge, out_valid three edges after driving
  task automatic send_one(input logic [23:0] cw, input logic [17:0] ed, input logic ee);
    @(posedge clock); #1;
    bus_a.codein   = cw;
    bus_a.in_valid = 1'b1;
    @(negedge clock);
    chk("one_in_ready", 32'(bus_a.in_ready), 32'd1);
    @(posedge clock); #1;
    bus_a.in_valid = 1'b0;
    @(negedge clock);
    chk("lat_edge1_out_valid", 32'(bus_a.out_valid), 32'd0);
    @(negedge clock);
    chk("lat_edge2_out_valid", 32'(bus_a.out_valid), 32'd0);
    @(negedge clock);
    chk("lat_edge3_out_valid", 32'(bus_a.out_valid), 32'd1);
    chk("one_dataout", 32'(bus_a.dataout), 32'(ed));
    chk("one_out_err", 32'(bus_a.out_err), 32'(ee));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  vec_t        vt [8];
  logic [3:0]  grp [10];
  logic [17:0] b2b_exp [10];
  logic [23:0] w [5];
  exp_t        e;
  logic [17:0] held;
  bit          have;
  int          n;
  int          acc;
  int          deliv;

  initial begin
    vt[0] = '{24'h000000, 18'd0,      1'b0};
    vt[1] = '{24'h000001, 18'd1,      1'b0};
    vt[2] = '{24'h080000, 18'd6765,   1'b0};
    vt[3] = '{24'h100000, 18'd10946,  1'b0};
    vt[4] = '{24'hF00000, 18'd132339, 1'b0};
    vt[5] = '{24'h200005, 18'd3,      1'b1};
    vt[6] = '{24'h4FFFFF, 18'd17710,  1'b1};
    vt[7] = '{24'h0FFFFF, 18'd17710,  1'b0};
    grp = '{4'b0000, 4'b0001, 4'b1000, 4'b1001, 4'b0011,
            4'b1100, 4'b0110, 4'b0111, 4'b1110, 4'b1111};
    b2b_exp = '{18'd1, 18'd10947, 18'd28658, 18'd39604, 18'd57315,
                18'd75026, 18'd92737, 18'd103683, 18'd121394, 18'd132340};

    bus_a.in_valid  = 1'b0;
    bus_a.codein    = 24'h000000;
    bus_a.out_ready = 1'b1;
    reset_n         = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // Reset state
    @(negedge clock);
    chk("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    chk("rst_dataout", 32'(bus_a.dataout), 32'd0);
    chk("rst_out_err", 32'(bus_a.out_err), 32'd0);
    chk("rst_err_count", 32'(err_count_a), 32'd0);
    chk("rst_in_ready", 32'(bus_a.in_ready), 32'd1);

    // Directed vector table
    for (int i = 0; i < 8; i++) send_one(vt[i].code, vt[i].data, vt[i].err);
    chk("err_count_after_table", 32'(err_count_a), 32'd2);

    // All legal groups back to back with bit 0 set
    n = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clock); #1;
      if (c < 10) begin
        bus_a.in_valid = 1'b1;
        bus_a.codein   = {grp[c], 19'd0, 1'b1};
      end else begin
        bus_a.in_valid = 1'b0;
      end
      @(negedge clock);
      if (c < 10) chk("b2b_in_ready", 32'(bus_a.in_ready), 32'd1);
      if (bus_a.out_valid) begin
        if (n == 0) chk("b2b_first_latency", 32'(c), 32'd3);
        if (n < 10) chk("b2b_data", 32'(bus_a.dataout), 32'(b2b_exp[n]));
        n++;
      end else if (n > 0 && n < 10) begin
        chk("b2b_no_gap", 32'(bus_a.out_valid), 32'd1);
      end
    end
    chk("b2b_count", 32'(n), 32'd10);

    // Stall: out_ready low for 6 cycles while offering 5 words
    for (int j = 0; j < 5; j++) w[j] = {4'b0011, 20'(j * 1000 + 7)};
    acc  = 0;
    have = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clock); #1;
      bus_a.out_ready = 1'b0;
      bus_a.in_valid  = (acc < 5);
      if (acc < 5) bus_a.codein = w[acc];
      @(negedge clock);
      if (bus_a.in_valid && bus_a.in_ready) acc++;
      if (bus_a.out_valid) begin
        if (!have) begin
          held = bus_a.dataout;
          have = 1'b1;
        end else begin
          chk("stall_dataout_stable", 32'(bus_a.dataout), 32'(held));
        end
      end
    end
    chk("stall_accepted", 32'(acc), 32'd3);
    chk("stall_in_ready_low", 32'(bus_a.in_ready), 32'd0);
    chk("stall_out_valid", 32'(bus_a.out_valid), 32'd1);
    e = ref_decode(w[0]);
    chk("stall_head", 32'(bus_a.dataout), 32'(e.data));
    deliv = 0;
    for (int c = 0; c < 30 && deliv < 5; c++) begin
      @(posedge clock); #1;
      bus_a.out_ready = 1'b1;
      bus_a.in_valid  = (acc < 5);
      if (acc < 5) bus_a.codein = w[acc];
      @(negedge clock);
      if (bus_a.out_valid && bus_a.out_ready) begin
        if (deliv < 5) begin
          e = ref_decode(w[deliv]);
          chk("stall_order", 32'(bus_a.dataout), 32'(e.data));
        end
        deliv++;
      end
      if (bus_a.in_valid && bus_a.in_ready) acc++;
    end
    chk("stall_delivered", 32'(deliv), 32'd5);

    // Mid-stream reset with three words in flight
    @(posedge clock); #1;
    bus_a.in_valid = 1'b0;
    repeat (3) @(posedge clock);
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      bus_a.in_valid = 1'b1;
      bus_a.codein   = {4'b0111, 20'(c * 4099 + 11)};
    end
    @(posedge clock); #1;
    bus_a.in_valid = 1'b0;
    reset_n        = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("mrst_in_ready", 32'(bus_a.in_ready), 32'd1);
    chk("mrst_err_count", 32'(err_count_a), 32'd0);
    chk("mrst_dataout", 32'(bus_a.dataout), 32'd0);
    for (int c = 0; c < 4; c++) begin
      chk("mrst_no_stale_valid", 32'(bus_a.out_valid), 32'd0);
      @(negedge clock);
    end
    e = ref_decode(24'h912345);
    send_one(24'h912345, e.data, e.err);

    // Random traffic against the scoreboard
    for (int c = 0; c < 400; c++) begin
      @(posedge clock); #1;
      bus_a.in_valid  = ($urandom_range(0, 3) != 0);
      bus_a.codein    = 24'($urandom);
      bus_a.out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clock); #1;
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b1;
    for (int c = 0; c < 20 && (sb_q.size() != 0 || bus_a.out_valid); c++) @(negedge clock);
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
    chk("drain_out_valid", 32'(bus_a.out_valid), 32'd0);
    @(negedge clock);
    chk("err_b_saturated", 32'(err_count_b), (model_a >= 3) ? 32'd3 : 32'(model_a));
    chk("err_a_final", 32'(err_count_a), 32'(model_a));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
